multicycle_control: RTL
=======================

# multicycle_control

Sequencing controller for the multi-cycle variant of the MIPS datapath. It is a Moore-style FSM that steps one instruction through fetch, decode, execute, memory and writeback over 3–5 cycles. It drives every datapath mux select, write enable and memory strobe, and stalls on a memory ready handshake. It replaces the single-cycle combinational decoder when the datapath shares one memory port and one ALU across cycles.

## Interface
Parameters:
- CNT_W, 16, width of retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  1 = fetch new instructions; sampled only in IDLE and at instruction end
- opcode  in  6  IR[31:26], valid from DECODE onward
- mem_ready  in  1  memory completes the current read/write this cycle
- PCWrite, PCWriteCond, PCWriteCondNe  out  1 each  unconditional PC load / load if zero / load if not zero
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut
- MemRead, MemWrite  out  1 each  memory strobes
- IRWrite  out  1  instruction register load
- MemtoReg, RegDst, RegWrite  out  1 each  writeback controls
- ALUSrcA  out  1  0 = PC, 1 = reg A
- ALUSrcB  out  2  00 = reg B, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
- ALUOp  out  3  {R-type, branch, add}: 100 / 010 / 001
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- illegal_op  out  1  one-cycle pulse on an undecodable opcode
- retired  out  CNT_W  count of completed legal instructions, wraps
- state  out  4  current state encoding (debug)

## Operation
- States and encodings: IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_READ 4, MEM_WB 5, MEM_WRITE 6, EXECUTE 7, ALU_WB 8, BRANCH 9, JUMP 10. Encodings 11–15 are unreachable and recover to IDLE on the next clock.
- Outputs not listed for a state are 0.
- IDLE: all outputs 0. Moves to FETCH when run = 1.
- FETCH: MemRead = 1, ALUSrcB = 01, ALUOp = 001. IRWrite = PCWrite = mem_ready (the only Mealy terms). Stays in FETCH until mem_ready, then moves to DECODE.
- DECODE: ALUSrcB = 11, ALUOp = 001 (branch target into ALUOut). Next state by opcode:
  - 100011 (lw) or 101011 (sw) -> MEM_ADDR
  - 000000 -> EXECUTE
  - 000100 (beq) or 000101 (bne) -> BRANCH
  - 000010 (j) -> JUMP
  - any other opcode -> illegal_op = 1 in the next cycle, then FETCH (or IDLE if run = 0). Not counted in retired.
- MEM_ADDR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 001. Goes to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: MemRead = 1, IorD = 1. Waits for mem_ready, then MEM_WB.
- MEM_WB: RegWrite = 1, MemtoReg = 1. Instruction ends.
- MEM_WRITE: MemWrite = 1, IorD = 1. Waits for mem_ready. Instruction ends on the mem_ready cycle.
- EXECUTE: ALUSrcA = 1, ALUOp = 100. Then ALU_WB.
- ALU_WB: RegWrite = 1, RegDst = 1. Instruction ends.
- BRANCH: ALUSrcA = 1, ALUOp = 010, PCSource = 01. PCWriteCond = 1 if opcode = 000100; PCWriteCondNe = 1 if opcode = 000101. Instruction ends.
- JUMP: PCWrite = 1, PCSource = 10. Instruction ends.
- Instruction end: retired increments by 1 (wraps at 2^CNT_W). Next state is FETCH if run = 1, otherwise IDLE.
- Dropping run mid-instruction never aborts the instruction; it completes, then the FSM goes to IDLE.

## Timing
- Reset (asynchronous, immediate): state = IDLE, all control outputs 0, illegal_op = 0, retired = 0. Applies mid-instruction, including while waiting on memory.
- The state register and retired update on the rising edge of clk.
- Outputs are combinational from state, except the FETCH IRWrite/PCWrite terms, which also depend on mem_ready.
- illegal_op is registered.
- Latency with mem_ready tied to 1:
  - lw: 5 cycles
  - R-type and sw: 4 cycles
  - beq, bne and j: 3 cycles
- Each cycle with mem_ready = 0 in FETCH, MEM_READ or MEM_WRITE adds one cycle. All outputs are held stable during the stall.
- The first FETCH is one cycle after the run = 1 sample in IDLE.

## Test plan
- Reset, then run = 1, mem_ready = 1, opcode = 000000: state sequence 0,1,2,7,8,1. RegWrite = RegDst = 1 only in state 8. retired = 1 after 5 clocks.
- lw (100011) with mem_ready low for 2 cycles in MEM_READ: state 4 held for 3 cycles, MemRead = IorD = 1 throughout, then MEM_WB with MemtoReg = 1. Total 7 cycles.
- beq then bne: PCWriteCond = 1 only in the beq BRANCH cycle, PCWriteCondNe = 1 only in the bne BRANCH cycle, PCSource = 01 and ALUOp = 010 in both.
- opcode = 111111: illegal_op pulses exactly one cycle, FSM returns to FETCH, retired is unchanged.
- Clear run during EXECUTE: ALU_WB completes, then IDLE with all outputs 0. Drive rst_n low mid-MEM_WRITE: outputs go to 0 immediately, retired = 0.
- Preload retired near wrap by running 2^CNT_W jumps (CNT_W = 4 in the bench): counter wraps to 0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencing controller: a Moore FSM that walks one instruction
// through fetch/decode/execute/memory/writeback and stalls on the memory handshake.
module multicycle_control #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             PCWriteCondNe,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WRITE = 4'd6,
        EXECUTE   = 4'd7,
        ALU_WB    = 4'd8,
        BRANCH    = 4'd9,
        JUMP      = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t cur_state;
    state_t nxt_state;
    logic   instr_end;
    logic   bad_op;

    // Next-state logic; every instruction-ending state funnels through instr_end
    // so that run is sampled in exactly one place per instruction.
    always_comb begin
        nxt_state = IDLE;
        instr_end = 1'b0;
        bad_op    = 1'b0;
        case (cur_state)
            IDLE:      nxt_state = run ? FETCH : IDLE;
            FETCH:     nxt_state = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:   nxt_state = MEM_ADDR;
                    OP_RTYPE:       nxt_state = EXECUTE;
                    OP_BEQ, OP_BNE: nxt_state = BRANCH;
                    OP_J:           nxt_state = JUMP;
                    default: begin
                        bad_op    = 1'b1;
                        nxt_state = run ? FETCH : IDLE;
                    end
                endcase
            end
            MEM_ADDR:  nxt_state = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
            MEM_READ:  nxt_state = mem_ready ? MEM_WB : MEM_READ;
            MEM_WB:    instr_end = 1'b1;
            MEM_WRITE: begin
                if (mem_ready) instr_end = 1'b1;
                else           nxt_state = MEM_WRITE;
            end
            EXECUTE:   nxt_state = ALU_WB;
            ALU_WB:    instr_end = 1'b1;
            BRANCH:    instr_end = 1'b1;
            JUMP:      instr_end = 1'b1;
            default:   nxt_state = IDLE;
        endcase
        if (instr_end) nxt_state = run ? FETCH : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state  <= IDLE;
            illegal_op <= 1'b0;
            retired    <= '0;
        end else begin
            cur_state  <= nxt_state;
            illegal_op <= bad_op;
            if (instr_end) retired <= retired + CNT_W'(1);
        end
    end

    // Datapath controls decode from the state alone, except the fetch-complete
    // IR/PC loads which must follow mem_ready in the same cycle.
    always_comb begin
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        PCWriteCondNe = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        MemtoReg      = 1'b0;
        RegDst        = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        ALUOp         = 3'b000;
        PCSource      = 2'b00;
        case (cur_state)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                ALUOp   = 3'b001;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                ALUOp   = 3'b001;
            end
            MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = 3'b001;
            end
            MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = 3'b100;
            end
            ALU_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            BRANCH: begin
                ALUSrcA       = 1'b1;
                ALUOp         = 3'b010;
                PCSource      = 2'b01;
                PCWriteCond   = (opcode == OP_BEQ);
                PCWriteCondNe = (opcode == OP_BNE);
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            default: ;
        endcase
    end

    assign state = cur_state;

endmodule
